// File: rtl/led_pkg.sv
// Shared mode encodings and mode-advance helper for the LED sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SLOW  = 2'd1,
    MODE_FAST  = 2'd2,
    MODE_CHASE = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    unique case (m)
      MODE_OFF:   n = MODE_SLOW;
      MODE_SLOW:  n = MODE_FAST;
      MODE_FAST:  n = MODE_CHASE;
      MODE_CHASE: n = MODE_OFF;
      default:    n = MODE_OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer, debounce counter and one-cycle press pulse
// on a debounced 1->0 transition of an active-low push-button.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Released (1) is the idle level, so reset can never fake a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED blink-mode sequencer (OFF/SLOW/FAST/CHASE).
// Optional LED_ALT_PHASE_EN: alternating even/odd LEDs in SLOW/FAST.
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int NUM_LEDS        = 8,
  parameter int SLOW_DIV        = 25000000,
  parameter int FAST_DIV        = 250000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                KEY,
  output logic [NUM_LEDS-1:0] LEDG,
  output logic [1:0]          MODE
);

  localparam int MAXD = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW   = $clog2(MAXD);
  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
  localparam logic [NUM_LEDS-1:0] CHASE_INIT =
    {{(NUM_LEDS-1){1'b0}}, 1'b1};

  mode_e               mode_q;
  mode_e               mode_d;
  logic [CW-1:0]       pre_q;
  logic [CW-1:0]       pre_d;
  logic                phase_q;
  logic                phase_d;
  logic [NUM_LEDS-1:0] chase_q;
  logic [NUM_LEDS-1:0] chase_d;
  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] led_d;
  logic [NUM_LEDS-1:0] blink;
  logic [CW-1:0]       last;
  logic                press;
  logic                tick;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .key_i  (KEY),
    .press_o(press)
  );

`ifdef LED_ALT_PHASE_EN
  logic [NUM_LEDS-1:0] odd_bits;
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_odd
    assign odd_bits[i] = (i % 2) == 1;
  end
  assign blink = {NUM_LEDS{phase_q}} ^ odd_bits;
`else
  assign blink = {NUM_LEDS{phase_q}};
`endif

  assign last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
  assign tick = (mode_q != MODE_OFF) && (pre_q == last);

  // A press outranks a coincident tick: the new mode starts clean.
  always_comb begin
    mode_d  = mode_q;
    pre_d   = pre_q;
    phase_d = phase_q;
    chase_d = chase_q;
    if (press) begin
      mode_d  = next_mode(mode_q);
      pre_d   = '0;
      phase_d = 1'b0;
      chase_d = CHASE_INIT;
    end else if (mode_q == MODE_OFF) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d   = '0;
      phase_d = ~phase_q;
      chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
    end else begin
      pre_d = pre_q + CW'(1);
    end
  end

  always_comb begin
    led_d = '0;
    unique case (mode_q)
      MODE_OFF:   led_d = '0;
      MODE_SLOW:  led_d = blink;
      MODE_FAST:  led_d = blink;
      MODE_CHASE: led_d = chase_q;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q  <= MODE_OFF;
      pre_q   <= '0;
      phase_q <= 1'b0;
      chase_q <= CHASE_INIT;
      led_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      chase_q <= chase_d;
      led_q   <= led_d;
    end
  end

  assign LEDG = led_q;
  assign MODE = mode_q;

endmodule
